// File: rtl/stim_gen_if.sv
// Stimulus-generator bus: control and seed inputs towards the generator,
// generated vectors and status flags back to the consumer.
interface stim_gen_if #(
   parameter int unsigned X_WIDTH = 8,
   parameter int unsigned A_WIDTH = 3
);
   logic               en;
   logic               load;
   logic [1:0]         mode;
   logic [X_WIDTH-1:0] seed_x;
   logic [A_WIDTH-1:0] seed_a;
   logic [X_WIDTH-1:0] x;
   logic [A_WIDTH-1:0] a;
   logic               valid;
   logic               wrap;
   logic               done;

   modport master (
      input  en, load, mode, seed_x, seed_a,
      output x, a, valid, wrap, done
   );

   modport slave (
      output en, load, mode, seed_x, seed_a,
      input  x, a, valid, wrap, done
   );
endinterface

// File: rtl/stim_gen.sv
// Parametrised stimulus generator: joint count, nested sweep, Galois LFSR and
// walking-one sequences with seed load, wrap pulse and sticky sweep-done flag.
module stim_gen #(
   parameter int unsigned       X_WIDTH   = 8,
   parameter int unsigned       A_WIDTH   = 3,
   parameter logic [X_WIDTH-1:0] LFSR_TAPS = X_WIDTH'(8'hB8)
) (
   input logic       clk,
   input logic       rst,
   stim_gen_if.master bus_io
);
   localparam int unsigned CntWidth = X_WIDTH + A_WIDTH;

   typedef enum logic [1:0] {
      ModeCount = 2'd0,
      ModeSweep = 2'd1,
      ModeLfsr  = 2'd2,
      ModeWalk  = 2'd3
   } mode_e;

   logic [X_WIDTH-1:0]  x_q, x_d;
   logic [A_WIDTH-1:0]  a_q, a_d;
   logic                valid_q, valid_d;
   logic                wrap_q, wrap_d;
   logic                done_q, done_d;
   logic [CntWidth-1:0] sweep_cnt;
   logic                x_onehot;
   mode_e               mode;

   assign mode      = mode_e'(bus_io.mode);
   assign sweep_cnt = {x_q, a_q} + CntWidth'(1);
   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   assign x_onehot  = (x_q != '0) && ((x_q & (x_q - X_WIDTH'(1))) == '0);

   always_comb begin
      x_d     = x_q;
      a_d     = a_q;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      done_d  = done_q;
      if (bus_io.load) begin
         x_d     = bus_io.seed_x;
         a_d     = bus_io.seed_a;
         valid_d = 1'b1;
         done_d  = 1'b0;
      end else if (bus_io.en) begin
         valid_d = 1'b1;
         unique case (mode)
            ModeCount: begin
               x_d    = x_q + X_WIDTH'(1);
               a_d    = a_q + A_WIDTH'(1);
               wrap_d = &x_q;
            end
            ModeSweep: begin
               {x_d, a_d} = sweep_cnt;
               wrap_d     = &{x_q, a_q};
               done_d     = done_q | (&{x_q, a_q});
            end
            ModeLfsr: begin
               // All-zero is the LFSR lock-up state; force it back onto the sequence.
               if (x_q == '0) begin
                  x_d = X_WIDTH'(1);
               end else begin
                  x_d = (x_q >> 1) ^ (x_q[0] ? LFSR_TAPS : '0);
               end
               a_d    = a_q + A_WIDTH'(1);
               wrap_d = (x_d == X_WIDTH'(1));
            end
            ModeWalk: begin
               if (x_onehot) begin
                  x_d = {x_q[X_WIDTH-2:0], x_q[X_WIDTH-1]};
               end else begin
                  x_d = X_WIDTH'(1);
               end
               a_d    = a_q + A_WIDTH'(1);
               wrap_d = (x_d == X_WIDTH'(1));
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q     <= '0;
         a_q     <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         x_q     <= x_d;
         a_q     <= a_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
         done_q  <= done_d;
      end
   end

   assign bus_io.x     = x_q;
   assign bus_io.a     = a_q;
   assign bus_io.valid = valid_q;
   assign bus_io.wrap  = wrap_q;
   assign bus_io.done  = done_q;
endmodule

// File: doc/stim_gen.md
# stim_gen

Parametrised stimulus generator for module testbenches. It drives an X_WIDTH-bit data vector `x` and an A_WIDTH-bit select vector `a` into a device under test. It replaces hard-coded free-running 8-bit/3-bit incrementers with four selectable sequence modes, plus enable, seed load, wrap and sweep-done flags. The block is synthesisable; each testbench instantiates it next to the DUT and shares one `clk`.

## Interface
- X_WIDTH, 8: width of `x` and `seed_x`; range 2..32.
- A_WIDTH, 3: width of `a` and `seed_a`; range 1..16.
- LFSR_TAPS, 8'hB8: Galois feedback mask for mode 2, X_WIDTH bits; the default is maximal-length for X_WIDTH=8.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance the sequence by one step on this edge.
- load  in  1  synchronous seed load; has priority over `en`.
- mode  in  2  0 = joint count, 1 = nested sweep, 2 = LFSR, 3 = walking one.
- seed_x  in  X_WIDTH  value loaded into `x` on `load`.
- seed_a  in  A_WIDTH  value loaded into `a` on `load`.
- x  out  X_WIDTH  data stimulus (register output).
- a  out  A_WIDTH  select stimulus (register output).
- valid  out  1  high for the cycle after an `en` step or a `load`.
- wrap  out  1  one-cycle pulse; `x`/`a` have just returned to the sequence start.
- done  out  1  sticky; set when a mode-1 sweep completes.

## Operation
- Priority on each edge: `rst` > `load` > `en` > hold.
- Reset: `x`=0, `a`=0, `valid`=0, `wrap`=0, `done`=0.
- Load:
  - `x`<=`seed_x`, `a`<=`seed_a`, `wrap`<=0, `done`<=0, `valid`<=1.
  - No check is made on the seed; the guards below handle illegal seeds.
- Step (`en`=1, `load`=0), by `mode`:
  - 0, joint count: `x`<=`x`+1 and `a`<=`a`+1, each modulo 2^width independently. `wrap`<=1 when `x` goes from all-ones to 0.
  - 1, nested sweep: {`x`,`a`} is one (X_WIDTH+A_WIDTH)-bit counter with `a` as the LSBs, incremented by 1. `wrap`<=1 and `done`<=1 when it goes from all-ones to 0. A full sweep visits every (x,a) pair exactly once.
  - 2, LFSR: `x`<=(`x`>>1) ^ (`x`[0] ? LFSR_TAPS : 0). If `x`==0, `x`<=1 instead (lock-up guard). `a`<=`a`+1. `wrap`<=1 when the new `x`==1.
  - 3, walking one: if `x` is one-hot, `x`<={`x`[X_WIDTH-2:0],`x`[X_WIDTH-1]}. Otherwise (0 or multi-hot) `x`<=1. `a`<=`a`+1. `wrap`<=1 when the new `x`==1.
- Hold (`en`=0, `load`=0): `x`, `a` and `done` keep their values; `valid`<=0 and `wrap`<=0.
- `done` is set only in mode 1. It is cleared only by `rst` or `load`, and stays set while the sweep restarts.
- A change of `mode` applies at the next step. `x` and `a` are not reset; the guards in modes 2 and 3 recover any illegal value in one step.
- All arithmetic is unsigned, modulo the width, with no saturation.

## Timing
- Single clock domain; no combinational path from any input to any output.
- Latency: `x`, `a`, `valid` and `wrap` change on the edge that samples `en` or `load`, i.e. they are visible 1 cycle later.
- With `en` held high, one new vector is produced per cycle.
- Sequence periods (wrap to wrap, `en` continuously high):
  - mode 0: 2^X_WIDTH steps;
  - mode 1: 2^(X_WIDTH+A_WIDTH) steps;
  - mode 2: 2^X_WIDTH−1 steps for maximal taps;
  - mode 3: X_WIDTH steps.
- `rst` during a sweep: all outputs are at their reset values on the next cycle, regardless of `en`, `load` or `mode`.
- `load` and `en` in the same cycle: the load wins and no step is taken.

## Test plan
- Reset, then `mode`=0 with `en`=1 for 256 cycles → `x`=0,1,2…255,0 and `a`=0..7 repeating. `wrap` pulses only on the cycle where `x` returns to 0. `done` stays 0.
- `mode`=1, 8/3 defaults, `en`=1 for 2048 cycles → each (x,a) pair appears once and `a` cycles fastest. `wrap` and `done` go high when {x,a} returns to 0. After 5 more cycles `done` is still 1 and `wrap` is 0.
- `mode`=2, `load` with `seed_x`=0, then `en` → `x` becomes 1 after one step. 255 consecutive values are distinct and non-zero, and `wrap` pulses every 255 cycles.
- `mode`=3, `load` with `seed_x`=8'h05, then `en` for 9 cycles → `x`=01,02,04…80,01. `wrap` pulses on the first 01 and again 8 steps later.
- Stall and priority: toggle `en` every other cycle → `x` and `a` hold and `valid`=0 on idle cycles. Assert `load`=1 and `en`=1 with `seed_x`=8'h3C, `seed_a`=5 → next cycle `x`=3C, `a`=5, `valid`=1, `done`=0.
- Reset mid-sweep: `mode`=1 at {x,a}=0x123 with `en`=1, assert `rst` for one cycle → next cycle `x`=0, `a`=0, `valid`=0, `wrap`=0, `done`=0. Counting resumes from 0 after `rst` drops.
